// File: rtl/tdm_demux4_pkg.sv
// Shared types for the 4-slot TDM demultiplexer: channel count, slot index and framer state.
package tdm_demux4_pkg;

  localparam int unsigned NUM_CH = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {HUNT, LOCKED} state_e;

  function automatic logic [NUM_CH-1:0] slot_onehot(input slot_t s);
    logic [NUM_CH-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-4 slot counter with synchronous clear, load-to-1 and increment (priority in that order).
module tdm_slot_counter
  import tdm_demux4_pkg::*;
(
  input  logic  clk,
  input  logic  clear,
  input  logic  load1,
  input  logic  inc,
  output slot_t slot
);

  slot_t slot_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      slot_q <= '0;
    end else if (load1) begin
      slot_q <= slot_t'(1);
    end else if (inc) begin
      slot_q <= slot_q + slot_t'(1);
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer with frame_sync hunting/locking and resync on misplaced sync.
// Define TDM_DEMUX4_FRAME_BUF_EN to present whole frames at once from shadow registers.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int unsigned CH_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_W-1:0]   din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [CH_W-1:0]   a,
  output logic [CH_W-1:0]   b,
  output logic [CH_W-1:0]   c,
  output logic [CH_W-1:0]   d,
  output logic [NUM_CH-1:0] ch_valid,
  output logic              frame_done,
  output logic              sync_err
);

  state_e state_q, state_d;
  slot_t  slot, sel;
  logic   route, load1, inc, err, done;

  tdm_slot_counter u_slot_counter (
    .clk   (clk),
    .clear (!rst_n),
    .load1 (load1),
    .inc   (inc),
    .slot  (slot)
  );

  always_comb begin
    state_d = state_q;
    route   = 1'b0;
    sel     = '0;
    load1   = 1'b0;
    inc     = 1'b0;
    err     = 1'b0;
    done    = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            state_d = LOCKED;
            route   = 1'b1;
            load1   = 1'b1;
          end
        end
        LOCKED: begin
          route = 1'b1;
          // A sync away from slot 0 restarts the frame on this sample.
          if (frame_sync && (slot != '0)) begin
            load1 = 1'b1;
            err   = 1'b1;
          end else begin
            sel  = slot;
            inc  = 1'b1;
            done = (slot == slot_t'(NUM_CH - 1));
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  logic [CH_W-1:0] ch_q [NUM_CH];

`ifdef TDM_DEMUX4_FRAME_BUF_EN
  logic [CH_W-1:0] sh_a_q, sh_b_q, sh_c_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
      sh_a_q     <= '0;
      sh_b_q     <= '0;
      sh_c_q     <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      ch_valid   <= '0;
      frame_done <= done;
      sync_err   <= err;
      if (route) begin
        case (sel)
          2'd0: sh_a_q <= din;
          2'd1: sh_b_q <= din;
          2'd2: sh_c_q <= din;
          default: begin
            // Slot 3 is only reached after slots 0..2 of the same frame refreshed the shadows.
            ch_q[0]  <= sh_a_q;
            ch_q[1]  <= sh_b_q;
            ch_q[2]  <= sh_c_q;
            ch_q[3]  <= din;
            ch_valid <= '1;
          end
        endcase
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      ch_valid   <= '0;
      frame_done <= done;
      sync_err   <= err;
      if (route) begin
        ch_q[sel] <= din;
        ch_valid  <= slot_onehot(sel);
      end
    end
  end
`endif

  assign a = ch_q[0];
  assign b = ch_q[1];
  assign c = ch_q[2];
  assign d = ch_q[3];

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus randomized traffic vs a frame model.
module tb_tdm_demux4;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n, din_valid, frame_sync;
  logic [W-1:0] din;
  logic [W-1:0] a, b, c, d;
  logic [3:0]   ch_valid;
  logic         frame_done, sync_err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.CH_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  // Reference model: a frame is a list of samples starting at slot 0.
  bit           m_locked;
  int           m_pos;
  logic [W-1:0] m_frame[$];
  logic [W-1:0] ex_ch[4];
  logic [3:0]   ex_cv;
  logic         ex_done, ex_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic deliver(input int pos, input logic [W-1:0] v);
    if (pos == 0) m_frame.delete();
    m_frame.push_back(v);
`ifdef TDM_DEMUX4_FRAME_BUF_EN
    if (m_frame.size() == 4) begin
      for (int i = 0; i < 4; i++) ex_ch[i] = m_frame[i];
      ex_cv = 4'hf;
    end
`else
    ex_ch[pos] = v;
    ex_cv      = 4'(1 << pos);
`endif
  endtask

  task automatic model(input logic r, input logic v, input logic fs, input logic [W-1:0] dv);
    ex_cv   = '0;
    ex_done = 1'b0;
    ex_err  = 1'b0;
    if (!r) begin
      m_locked = 0;
      m_pos    = 0;
      m_frame.delete();
      for (int i = 0; i < 4; i++) ex_ch[i] = '0;
    end else if (v) begin
      if (!m_locked) begin
        if (fs) begin
          m_locked = 1;
          deliver(0, dv);
          m_pos = 1;
        end
      end else if (fs && m_pos != 0) begin
        ex_err = 1'b1;
        deliver(0, dv);
        m_pos = 1;
      end else begin
        deliver(m_pos, dv);
        if (m_pos == 3) ex_done = 1'b1;
        m_pos = (m_pos + 1) % 4;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic fs, input logic [W-1:0] dv);
    rst_n      = r;
    din_valid  = v;
    frame_sync = fs;
    din        = dv;
    @(posedge clk);
    model(r, v, fs, dv);
    #1;
    check("a", a, ex_ch[0]);
    check("b", b, ex_ch[1]);
    check("c", c, ex_ch[2]);
    check("d", d, ex_ch[3]);
    check("ch_valid", ch_valid, ex_cv);
    check("frame_done", frame_done, ex_done);
    check("sync_err", sync_err, ex_err);
    check("onehot0", 32'($onehot0(ch_valid) || ch_valid == 4'hf), 1);
  endtask

  initial begin
    logic fs;
    rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; din = '0;
    // Reset takes priority over a concurrent valid sync sample.
    step(0, 1, 1, 4'h5);
    step(0, 0, 0, 4'h0);
    check("reset_cv", ch_valid, 4'h0);
    check("reset_a", a, 4'h0);

`ifndef TDM_DEMUX4_FRAME_BUF_EN
    // Basic frame 0,1,1,0.
    step(1, 1, 1, 4'h0); check("f1_cv0", ch_valid, 4'b0001);
    step(1, 1, 0, 4'h1); check("f1_cv1", ch_valid, 4'b0010);
    step(1, 1, 0, 4'h1); check("f1_cv2", ch_valid, 4'b0100);
    step(1, 1, 0, 4'h0); check("f1_cv3", ch_valid, 4'b1000);
    check("f1_done", frame_done, 1);
    check("f1_b", b, 4'h1);
    // Misplaced sync on the third sample.
    step(1, 1, 1, 4'h2);
    step(1, 1, 0, 4'h3);
    step(1, 1, 1, 4'h9); check("resync_err", sync_err, 1); check("resync_a", a, 4'h9);
    step(1, 1, 0, 4'h6); check("resync_b", b, 4'h6); check("resync_cv", ch_valid, 4'b0010);
`else
    step(1, 1, 1, 4'h1); check("fb_hold0", a, 4'h0);
    step(1, 1, 0, 4'h0); check("fb_cv1", ch_valid, 4'h0);
    step(1, 1, 0, 4'h1); check("fb_hold2", c, 4'h0);
    step(1, 1, 0, 4'h1);
    check("fb_cv", ch_valid, 4'hf); check("fb_a", a, 4'h1);
    check("fb_c", c, 4'h1); check("fb_d", d, 4'h1);
`endif

    // Reset mid-frame, then unsynced and hunting samples, then a sync.
    step(0, 0, 0, 4'h0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 4'(i + 7));
    check("hunt_cv", ch_valid, 4'h0);
    step(1, 1, 1, 4'h1);
    // Valid gaps: 8 samples over alternating valid.
    for (int i = 0; i < 16; i++) step(1, (i % 2) == 0, 0, 4'(i));

    for (int i = 0; i < 3000; i++) begin
      fs = ($urandom_range(0, 15) == 0) || (m_pos == 0 && $urandom_range(0, 1) == 1);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), fs, W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
